// File: rtl/traffic_pkg.sv
// rtl/traffic_pkg.sv - light codes, phase encoding and state-to-lights decode for the intersection
package traffic_pkg;

  typedef enum logic [1:0] {
    RED    = 2'b00,
    GREEN  = 2'b01,
    YELLOW = 2'b10
  } light_t;

  typedef enum logic [2:0] {
    MG  = 3'd0,
    MY  = 3'd1,
    AR1 = 3'd2,
    SG  = 3'd3,
    SY  = 3'd4,
    AR2 = 3'd5
  } state_t;

  typedef struct packed {
    light_t main_l;
    light_t side_l;
  } lights_t;

  // Unused encodings fall back to all-red so a corrupted state can never show two greens.
  function automatic lights_t state_lights(input state_t s);
    lights_t l;
    l.main_l = RED;
    l.side_l = RED;
    case (s)
      MG:      l.main_l = GREEN;
      MY:      l.main_l = YELLOW;
      SG:      l.side_l = GREEN;
      SY:      l.side_l = YELLOW;
      default: ;
    endcase
    return l;
  endfunction

endpackage

// File: rtl/traffic_phase_timer.sv
// rtl/traffic_phase_timer.sv - loadable saturating dwell down-counter
module traffic_phase_timer #(
  parameter int              CNT_W   = 8,
  parameter logic [CNT_W-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             done
);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= RST_VAL;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign done = (count == '0);

endmodule

// File: rtl/traffic_intersection_ctrl.sv
// rtl/traffic_intersection_ctrl.sv - main/side road sequencer with pedestrian walk alongside side green
module traffic_intersection_ctrl
  import traffic_pkg::*;
#(
  parameter int CNT_W    = 8,
  parameter int MAIN_MIN = 20,
  parameter int SIDE_GRN = 10,
  parameter int YEL_T    = 3,
  parameter int ALLRED_T = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       side_sensor,
  input  logic       ped_req,
  output logic [1:0] main_light,
  output logic [1:0] side_light,
  output logic       ped_walk,
  output logic       ped_pend
);

  localparam logic [CNT_W-1:0] MAIN_LD   = CNT_W'(MAIN_MIN - 1);
  localparam logic [CNT_W-1:0] SIDE_LD   = CNT_W'(SIDE_GRN - 1);
  localparam logic [CNT_W-1:0] YEL_LD    = CNT_W'(YEL_T - 1);
  localparam logic [CNT_W-1:0] ALLRED_LD = CNT_W'(ALLRED_T - 1);

  state_t           state_q, state_d;
  logic             tmr_load;
  logic [CNT_W-1:0] tmr_val;
  logic             tmr_done;
  logic             ped_pend_q, ped_pend_d;
  logic             walk_arm_q, walk_arm_d;
  logic             enter_sg;
  lights_t          lights;

  traffic_phase_timer #(
    .CNT_W   (CNT_W),
    .RST_VAL (ALLRED_LD)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (tmr_val),
    .done     (tmr_done)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= AR2;
      ped_pend_q <= 1'b0;
      walk_arm_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ped_pend_q <= ped_pend_d;
      walk_arm_q <= walk_arm_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    tmr_load = 1'b0;
    tmr_val  = '0;
    case (state_q)
      MG: begin
        if (tmr_done && (side_sensor || ped_pend_q)) begin
          state_d  = MY;
          tmr_load = 1'b1;
          tmr_val  = YEL_LD;
        end
      end
      MY: begin
        if (tmr_done) begin
          state_d  = AR1;
          tmr_load = 1'b1;
          tmr_val  = ALLRED_LD;
        end
      end
      AR1: begin
        if (tmr_done) begin
          state_d  = SG;
          tmr_load = 1'b1;
          tmr_val  = SIDE_LD;
        end
      end
      SG: begin
        if (tmr_done) begin
          state_d  = SY;
          tmr_load = 1'b1;
          tmr_val  = YEL_LD;
        end
      end
      SY: begin
        if (tmr_done) begin
          state_d  = AR2;
          tmr_load = 1'b1;
          tmr_val  = ALLRED_LD;
        end
      end
      AR2: begin
        if (tmr_done) begin
          state_d  = MG;
          tmr_load = 1'b1;
          tmr_val  = MAIN_LD;
        end
      end
      default: begin
        state_d  = AR2;
        tmr_load = 1'b1;
        tmr_val  = ALLRED_LD;
      end
    endcase
  end

  // A request arriving on the very clock that enters SG is served by that walk, not re-latched.
  assign enter_sg = (state_q == AR1) && tmr_done;

  always_comb begin
    ped_pend_d = ped_pend_q;
    walk_arm_d = walk_arm_q;
    if (enter_sg) begin
      ped_pend_d = 1'b0;
      walk_arm_d = ped_pend_q | ped_req;
    end else if (ped_req) begin
      ped_pend_d = 1'b1;
    end
  end

  assign lights     = state_lights(state_q);
  assign main_light = lights.main_l;
  assign side_light = lights.side_l;
  assign ped_walk   = (state_q == SG) && walk_arm_q;
  assign ped_pend   = ped_pend_q;

endmodule
